// File: rtl/lacc_mem_responder.sv
// Word-organised SRAM target for the lacc_data/lacc_drsp read channel, with a host preload port.
// Reads return the full aligned word two cycles after the handshake; sticky error flags and a read counter aid debug.
module lacc_mem_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lacc_data_valid,
    input  logic [31:0]          lacc_data_addr,
    input  logic [1:0]           lacc_data_size,
    output logic                 lacc_data_ready,
    output logic                 lacc_drsp_valid,
    output logic [31:0]          lacc_drsp_rdata,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [31:0]          host_wr_addr,
    input  logic [31:0]          host_wr_data,
    input  logic [3:0]           host_wr_strb,
    input  logic                 err_clr,
    output logic                 err_oor,
    output logic                 err_align,
    output logic [CNT_WIDTH-1:0] rd_cnt
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    logic [31:0]          mem [MEM_DEPTH];

    logic                 readyEn_q;
    logic                 s0Valid_q;
    logic [IDX_W-1:0]     s0Idx_q;
    logic                 s0Oor_q;
    logic                 rspValid_q;
    logic [31:0]          rspData_q;
    logic                 errOor_q, errOor_d;
    logic                 errAlign_q, errAlign_d;
    logic [CNT_WIDTH-1:0] rdCnt_q, rdCnt_d;

    logic [29:0]          rdWordOff, wrWordOff;
    logic [IDX_W-1:0]     rdIdx, wrIdx;
    logic                 rdOor, wrOor, rdMisalign;
    logic                 rdFire, wrFire;

    // Decode subtracts the base at word granularity; ADDR_BASE is word aligned so the low bits pass through.
    assign rdWordOff  = lacc_data_addr[31:2] - ADDR_BASE[31:2];
    assign wrWordOff  = host_wr_addr[31:2] - ADDR_BASE[31:2];
    assign rdIdx      = rdWordOff[IDX_W-1:0];
    assign wrIdx      = wrWordOff[IDX_W-1:0];
    assign rdOor      = (lacc_data_addr < ADDR_BASE) || ({2'b00, rdWordOff} >= MEM_DEPTH);
    assign wrOor      = (host_wr_addr < ADDR_BASE) || ({2'b00, wrWordOff} >= MEM_DEPTH);
    assign rdMisalign = (lacc_data_size == 2'd3)
                     || ((lacc_data_size == 2'd2) && (lacc_data_addr[1:0] != 2'b00))
                     || ((lacc_data_size == 2'd1) && lacc_data_addr[0]);

    assign host_wr_ready   = readyEn_q;
    assign lacc_data_ready = readyEn_q & ~host_wr_valid;
    assign rdFire          = lacc_data_valid & lacc_data_ready;
    assign wrFire          = host_wr_valid & host_wr_ready;

    always_ff @(posedge clk) begin
        if (wrFire && !wrOor) begin
            for (int k = 0; k < 4; k++) begin
                if (host_wr_strb[k]) begin
                    mem[wrIdx][8*k +: 8] <= host_wr_data[8*k +: 8];
                end
            end
        end
    end

    // A set condition on the same edge as err_clr wins; a clear plus a read leaves the counter at one.
    always_comb begin
        errOor_d   = errOor_q;
        errAlign_d = errAlign_q;
        rdCnt_d    = rdCnt_q;
        if (err_clr) begin
            errOor_d   = 1'b0;
            errAlign_d = 1'b0;
            rdCnt_d    = '0;
        end
        if ((rdFire && rdOor) || (wrFire && wrOor)) begin
            errOor_d = 1'b1;
        end
        if (rdFire && rdMisalign) begin
            errAlign_d = 1'b1;
        end
        if (rdFire && (rdCnt_d != {CNT_WIDTH{1'b1}})) begin
            rdCnt_d = rdCnt_d + CNT_WIDTH'(1);
        end
    end

    // The array read at stage 1 sees pre-write contents, so a write one edge after a read cannot leak into it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readyEn_q  <= 1'b0;
            s0Valid_q  <= 1'b0;
            s0Idx_q    <= '0;
            s0Oor_q    <= 1'b0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            errOor_q   <= 1'b0;
            errAlign_q <= 1'b0;
            rdCnt_q    <= '0;
        end else begin
            readyEn_q  <= 1'b1;
            s0Valid_q  <= rdFire;
            if (rdFire) begin
                s0Idx_q <= rdIdx;
                s0Oor_q <= rdOor;
            end
            rspValid_q <= s0Valid_q;
            if (s0Valid_q) begin
                rspData_q <= s0Oor_q ? 32'h0 : mem[s0Idx_q];
            end
            errOor_q   <= errOor_d;
            errAlign_q <= errAlign_d;
            rdCnt_q    <= rdCnt_d;
        end
    end

    assign lacc_drsp_valid = rspValid_q;
    assign lacc_drsp_rdata = rspData_q;
    assign err_oor         = errOor_q;
    assign err_align       = errAlign_q;
    assign rd_cnt          = rdCnt_q;

endmodule

// File: tb/tb_lacc_mem_responder.sv
// Self-checking bench for lacc_mem_responder: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level memory model.
module tb_lacc_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned CW    = 4;

    logic          clk;
    logic          rst;
    logic          lacc_data_valid;
    logic [31:0]   lacc_data_addr;
    logic [1:0]    lacc_data_size;
    logic          lacc_data_ready;
    logic          lacc_drsp_valid;
    logic [31:0]   lacc_drsp_rdata;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [31:0]   host_wr_addr;
    logic [31:0]   host_wr_data;
    logic [3:0]    host_wr_strb;
    logic          err_clr;
    logic          err_oor;
    logic          err_align;
    logic [CW-1:0] rd_cnt;

    lacc_mem_responder #(
        .MEM_DEPTH(DEPTH),
        .ADDR_BASE(BASE),
        .CNT_WIDTH(CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lacc_data_valid(lacc_data_valid),
        .lacc_data_addr (lacc_data_addr),
        .lacc_data_size (lacc_data_size),
        .lacc_data_ready(lacc_data_ready),
        .lacc_drsp_valid(lacc_drsp_valid),
        .lacc_drsp_rdata(lacc_drsp_rdata),
        .host_wr_valid  (host_wr_valid),
        .host_wr_ready  (host_wr_ready),
        .host_wr_addr   (host_wr_addr),
        .host_wr_data   (host_wr_data),
        .host_wr_strb   (host_wr_strb),
        .err_clr        (err_clr),
        .err_oor        (err_oor),
        .err_align      (err_align),
        .rd_cnt         (rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        wrEn;
        logic [31:0] wrOff;
        logic [31:0] wrData;
        logic [3:0]  wrStrb;
        logic [31:0] rdOff;
        logic [1:0]  rdSize;
        logic [31:0] expData;
        logic        expOor;
        logic        expAlign;
    } vec_t;

    int          total, bad, cyc;
    logic [31:0] mMem [DEPTH];
    logic        mReady, mOor, mAlign;
    int          mCnt;
    rsp_t        expQ[$];
    logic        gotRsp;
    logic [31:0] lastRsp;
    int          rspCount, rspRun, maxRun;
    logic [31:0] rspLog[$];
    vec_t        vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic mdlOor(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) / 4) >= DEPTH);
    endfunction

    function automatic int mdlIdx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic mdlMisalign(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic setIdle();
        lacc_data_valid = 1'b0;
        lacc_data_addr  = '0;
        lacc_data_size  = 2'd2;
        host_wr_valid   = 1'b0;
        host_wr_addr    = '0;
        host_wr_data    = '0;
        host_wr_strb    = '0;
        err_clr         = 1'b0;
    endtask

    task automatic setRead(input logic [31:0] addr, input logic [1:0] sz);
        lacc_data_valid = 1'b1;
        lacc_data_addr  = addr;
        lacc_data_size  = sz;
    endtask

    task automatic setWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        host_wr_valid = 1'b1;
        host_wr_addr  = addr;
        host_wr_data  = data;
        host_wr_strb  = strb;
    endtask

    // One clock: checks ready, advances the model for the coming edge, then checks outputs at the falling edge.
    task automatic applyStimulus();
        logic hsRd, hsWr;
        int   idx;
        #1;
        checkOutput("dataReady", 32'(lacc_data_ready), 32'(mReady & ~host_wr_valid));
        checkOutput("wrReady", 32'(host_wr_ready), 32'(mReady));
        hsRd = lacc_data_valid && mReady && !host_wr_valid;
        hsWr = host_wr_valid && mReady;
        if (err_clr) begin
            mOor   = 1'b0;
            mAlign = 1'b0;
            mCnt   = 0;
        end
        if (hsRd) begin
            expQ.push_back('{due: cyc + 2,
                             data: mdlOor(lacc_data_addr) ? 32'h0 : mMem[mdlIdx(lacc_data_addr)]});
            if (mdlOor(lacc_data_addr)) mOor = 1'b1;
            if (mdlMisalign(lacc_data_addr, lacc_data_size)) mAlign = 1'b1;
            if (mCnt < (1 << CW) - 1) mCnt++;
        end
        if (hsWr) begin
            if (mdlOor(host_wr_addr)) begin
                mOor = 1'b1;
            end else begin
                idx = mdlIdx(host_wr_addr);
                for (int k = 0; k < 4; k++) begin
                    if (host_wr_strb[k]) mMem[idx][8*k +: 8] = host_wr_data[8*k +: 8];
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) mReady = 1'b1;
        @(negedge clk);
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            checkOutput("drspValid", 32'(lacc_drsp_valid), 32'd1);
            checkOutput("drspData", lacc_drsp_rdata, expQ[0].data);
            void'(expQ.pop_front());
        end else begin
            checkOutput("drspIdle", 32'(lacc_drsp_valid), 32'd0);
        end
        if (lacc_drsp_valid) begin
            gotRsp  = 1'b1;
            lastRsp = lacc_drsp_rdata;
            rspLog.push_back(lacc_drsp_rdata);
            rspCount++;
            rspRun++;
            if (rspRun > maxRun) maxRun = rspRun;
        end else begin
            rspRun = 0;
        end
        checkOutput("errOor", 32'(err_oor), 32'(mOor));
        checkOutput("errAlign", 32'(err_align), 32'(mAlign));
        checkOutput("rdCnt", 32'(rd_cnt), 32'(mCnt));
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds for two edges and releases.
    task automatic resetDut();
        rst = 1'b0;
        setIdle();
        #1;
        checkOutput("rstDrspValid", 32'(lacc_drsp_valid), 32'd0);
        checkOutput("rstDataReady", 32'(lacc_data_ready), 32'd0);
        checkOutput("rstWrReady", 32'(host_wr_ready), 32'd0);
        checkOutput("rstErrOor", 32'(err_oor), 32'd0);
        checkOutput("rstErrAlign", 32'(err_align), 32'd0);
        checkOutput("rstRdCnt", 32'(rd_cnt), 32'd0);
        expQ.delete();
        mReady = 1'b0;
        mOor   = 1'b0;
        mAlign = 1'b0;
        mCnt   = 0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        checkOutput("rstHoldValid", 32'(lacc_drsp_valid), 32'd0);
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        setIdle();
        repeat (n) applyStimulus();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        gotRsp   = 1'b0;
        lastRsp  = '0;
        rspCount = 0;
        rspRun   = 0;
        maxRun   = 0;
        mReady   = 1'b0;
        mOor     = 1'b0;
        mAlign   = 1'b0;
        mCnt     = 0;
        rst      = 1'b0;
        setIdle();

        //            wrEn  wrOff          wrData          strb     rdOff          sz    expData         oor   align
        vecs[0]  = '{1'b1, 32'h10,        32'hDDCCBBAA, 4'hF,    32'h10,        2'd2, 32'hDDCCBBAA, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h10,        32'h0011_0000, 4'b0100, 32'h12,       2'd0, 32'hDD11BBAA, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h14,        32'hAABBCCDD, 4'hF,    32'h16,        2'd1, 32'hAABBCCDD, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h14,        32'hFFFFFFFF, 4'h0,    32'h14,        2'd2, 32'hAABBCCDD, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         32'h0,        4'h0,    32'h100,       2'd2, 32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         32'h0,        4'h0,    32'h12,        2'd2, 32'hDD11BBAA, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         32'h0,        4'h0,    32'h11,        2'd1, 32'hDD11BBAA, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         32'h0,        4'h0,    32'h10,        2'd3, 32'hDD11BBAA, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'hFFFFFFFC,  32'h00000001, 4'hF,    32'h10,        2'd2, 32'hDD11BBAA, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,        4'h0,    32'hFFFFFFFC,  2'd0, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'hFC,        32'h5A5A5A5A, 4'hF,    32'hFC,        2'd2, 32'h5A5A5A5A, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h100,       32'h00001234, 4'hF,    32'hFC,        2'd2, 32'h5A5A5A5A, 1'b1, 1'b0};

        @(negedge clk);
        resetDut();
        drain(1);

        $display("[TB] preloading %0d words", DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            setIdle();
            setWrite(BASE + 32'(4 * i), $urandom, 4'hF);
            applyStimulus();
        end
        drain(1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            setIdle();
            err_clr = 1'b1;
            applyStimulus();
            if (vecs[i].wrEn) begin
                setIdle();
                setWrite(BASE + vecs[i].wrOff, vecs[i].wrData, vecs[i].wrStrb);
                applyStimulus();
            end
            setIdle();
            setRead(BASE + vecs[i].rdOff, vecs[i].rdSize);
            gotRsp = 1'b0;
            applyStimulus();
            drain(3);
            checkOutput($sformatf("vec%0d.got", i), 32'(gotRsp), 32'd1);
            checkOutput($sformatf("vec%0d.data", i), lastRsp, vecs[i].expData);
            checkOutput($sformatf("vec%0d.oor", i), 32'(err_oor), 32'(vecs[i].expOor));
            checkOutput($sformatf("vec%0d.align", i), 32'(err_align), 32'(vecs[i].expAlign));
        end

        $display("[TB] back-to-back reads");
        setIdle();
        err_clr = 1'b1;
        applyStimulus();
        rspCount = 0;
        rspRun   = 0;
        maxRun   = 0;
        for (int j = 0; j < 4; j++) begin
            setIdle();
            setRead(BASE + 32'(4 * j), 2'd2);
            applyStimulus();
        end
        drain(3);
        checkOutput("burst.count", 32'(rspCount), 32'd4);
        checkOutput("burst.run", 32'(maxRun), 32'd4);
        checkOutput("burst.rdCnt", 32'(rd_cnt), 32'd4);

        $display("[TB] read/write collision and ordering");
        rspLog.delete();
        setIdle();
        setRead(BASE + 32'h20, 2'd2);
        setWrite(BASE + 32'h20, 32'hCAFEF00D, 4'hF);
        #1;
        checkOutput("collide.dataReady", 32'(lacc_data_ready), 32'd0);
        applyStimulus();
        host_wr_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        setIdle();
        setWrite(BASE + 32'h20, 32'h0BADBEEF, 4'hF);
        applyStimulus();
        setIdle();
        setRead(BASE + 32'h20, 2'd2);
        applyStimulus();
        drain(3);
        checkOutput("order.count", 32'(rspLog.size()), 32'd3);
        checkOutput("order.afterWr", (rspLog.size() > 0) ? rspLog[0] : 32'hxxxxxxxx, 32'hCAFEF00D);
        checkOutput("order.beforeWr", (rspLog.size() > 1) ? rspLog[1] : 32'hxxxxxxxx, 32'hCAFEF00D);
        checkOutput("order.newData", (rspLog.size() > 2) ? rspLog[2] : 32'hxxxxxxxx, 32'h0BADBEEF);

        $display("[TB] clear coinciding with new errors");
        setIdle();
        err_clr = 1'b1;
        setRead(BASE + 32'h100, 2'd3);
        applyStimulus();
        checkOutput("clrSet.oor", 32'(err_oor), 32'd1);
        checkOutput("clrSet.align", 32'(err_align), 32'd1);
        checkOutput("clrSet.rdCnt", 32'(rd_cnt), 32'd1);
        setIdle();
        err_clr = 1'b1;
        applyStimulus();
        checkOutput("clr.oor", 32'(err_oor), 32'd0);
        checkOutput("clr.rdCnt", 32'(rd_cnt), 32'd0);
        drain(3);

        $display("[TB] counter saturation");
        for (int j = 0; j < 20; j++) begin
            setIdle();
            setRead(BASE + 32'h14, 2'd2);
            applyStimulus();
        end
        drain(3);
        checkOutput("sat.rdCnt", 32'(rd_cnt), 32'd15);

        $display("[TB] reset with reads in flight");
        setIdle();
        setRead(BASE + 32'h10, 2'd2);
        applyStimulus();
        setRead(BASE + 32'h14, 2'd2);
        applyStimulus();
        resetDut();
        rspCount = 0;
        drain(4);
        checkOutput("rstDrop.count", 32'(rspCount), 32'd0);
        setIdle();
        setRead(BASE + 32'h10, 2'd2);
        gotRsp = 1'b0;
        applyStimulus();
        drain(3);
        checkOutput("retain.got", 32'(gotRsp), 32'd1);
        checkOutput("retain.data", lastRsp, 32'hDD11BBAA);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            int r;
            setIdle();
            err_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 6) begin
                r = int'($urandom_range(0, 99));
                if (r < 5)       lacc_data_addr = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
                else if (r < 15) lacc_data_addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
                else             lacc_data_addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                lacc_data_valid = 1'b1;
                lacc_data_size  = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 10) host_wr_addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
                else        host_wr_addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                host_wr_valid = 1'b1;
                host_wr_data  = $urandom;
                host_wr_strb  = 4'($urandom_range(0, 15));
            end
            applyStimulus();
        end
        drain(3);
        checkOutput("final.queueEmpty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lacc_mem_responder.md
Name: lacc_mem_responder

Overview:
- Local-accelerator memory responder; the target end of the lacc_data / lacc_drsp read channel that the CNN line buffer drives as initiator.
- Holds a word-organised on-chip SRAM model.
- Accepts read commands with valid/ready and returns aligned 32-bit words in order, at fixed latency, with no response backpressure.
- A host write port preloads feature maps and weights. Sticky error flags and a read counter support debug.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in the array (power of two, at least 4)
ADDR_BASE, 32'h0000_0000, byte address of word 0 (must be word aligned)
CNT_WIDTH, 16, width of the accepted-read counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
lacc_data_valid  input  1  read command valid
lacc_data_addr  input  32  byte address of the command
lacc_data_size  input  2  access size: 0=byte, 1=half, 2=word, 3=illegal
lacc_data_ready  output  1  command accepted when valid&ready at the rising edge
lacc_drsp_valid  output  1  response valid, one cycle per accepted command
lacc_drsp_rdata  output  32  full aligned word at addr[31:2]; the initiator shifts by addr[1:0]
host_wr_valid  input  1  host write valid
host_wr_ready  output  1  host write accepted when valid&ready
host_wr_addr  input  32  byte address; bits [1:0] are ignored
host_wr_data  input  32  write data
host_wr_strb  input  4  byte enables; bit k enables byte k
err_clr  input  1  clears err_oor and err_align
err_oor  output  1  sticky: a read or write hit an address outside the array
err_align  output  1  sticky: a read was misaligned or used size 3
rd_cnt  output  CNT_WIDTH  count of accepted reads; saturates; cleared by err_clr

Behaviour:
- Reset (rst low, asynchronous): the following are forced to 0: lacc_data_ready, host_wr_ready, lacc_drsp_valid, lacc_drsp_rdata, err_oor, err_align, rd_cnt, and both pipeline valid bits. Array contents are not reset. Reset asserted mid-operation drops in-flight responses; no drsp is emitted for them after release.
- Ready generation, from the first edge after reset release:
  - host_wr_ready = 1.
  - lacc_data_ready = ~host_wr_valid (combinational). A write has priority, so a read and a write never handshake on the same edge.
- Address decode, applied to both ports:
  - off = addr - ADDR_BASE (32-bit).
  - Out of range when addr < ADDR_BASE or off[31:2] >= MEM_DEPTH.
  - Word index = off[log2(MEM_DEPTH)+1:2].
- Read pipeline, fixed 2-cycle latency:
  - Stage 0: command handshake at edge E0 registers the index, the oor flag and a valid bit.
  - Stage 1: at edge E1 the array is read (read-first). Output registers load the word, or 0 if out of range. lacc_drsp_valid is high in the cycle after E1.
  - Response for a handshake at E0 is presented in cycle E0+2. One command per cycle gives one response per cycle. Order is preserved.
  - No drsp stall exists. Responses are never dropped or delayed.
- Write: on a handshake, each byte k with strb[k]=1 is written at that edge.
  - An out-of-range write is discarded and sets err_oor.
  - strb=0 completes the handshake as a no-op.
- Ordering rule:
  - A read handshaken before a write to the same word returns pre-write data, including a read at E0 with the write at E0+1.
  - A read handshaken after the write returns the new data.
- Error flags:
  - err_align sets on an accepted read when size=3, or size=2 with addr[1:0]!=0, or size=1 with addr[0]=1. Data is still returned.
  - err_oor sets on any out-of-range accepted read or write.
  - If set and err_clr occur on the same edge, set wins.
- rd_cnt increments on each read handshake and holds at all-ones.
  - err_clr zeroes it.
  - If err_clr and a handshake occur on the same edge, the result is 1.

Test Plan:
- Host writes 32'hDDCCBBAA to byte 0x10 with strb=4'hF; read word 0x10 issued at E0 -> drsp_valid in cycle E0+2 only, rdata=32'hDDCCBBAA.
- Host write strb=4'b0100 data 32'h0011_0000 to 0x10, then byte read at 0x12 -> rdata=32'hDD11BBAA, err_align stays 0.
- Reads to 0x0,0x4,0x8,0xC on consecutive cycles with host_wr_valid held low -> four consecutive drsp cycles with matching words in order; rd_cnt=4.
- host_wr_valid high while lacc_data_valid high -> lacc_data_ready=0, write completes, read accepted next cycle and returns the written data; the same-word read accepted one cycle before a write returns old data.
- Read at ADDR_BASE+4*MEM_DEPTH, and size=2 at addr 0x2 -> rdata=0 with err_oor=1 for the first, valid word with err_align=1 for the second; err_clr coinciding with a new error leaves the flag at 1.
- rst driven low with two reads in flight -> lacc_drsp_valid low immediately, no response after release; array retains the preloaded data.
